// File: rtl/gray_checker_if.sv
// Bus bundle between a Gray-count source/monitor and gray_checker.
// Ports: in_valid/gray_in (sample in), out_valid/bin_out/locked/step_err/wrap/err_count (result out).
// slave = checker side, master = the block that feeds samples and consumes results.
interface gray_checker_if #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic [WIDTH-1:0]     gray_in;
    logic                 out_valid;
    logic [WIDTH-1:0]     bin_out;
    logic                 locked;
    logic                 step_err;
    logic                 wrap;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, gray_in,
        input  out_valid, bin_out, locked, step_err, wrap, err_count
    );

    modport slave (
        input  in_valid, gray_in,
        output out_valid, bin_out, locked, step_err, wrap, err_count
    );
endinterface

// File: rtl/gray_checker.sv
// Gray-count decoder and step monitor: decodes each valid sample and flags non-successor steps.
// Latency 1 cycle for out_valid/bin_out/step_err/wrap/locked/err_count; one sample per cycle.
// No backpressure: every valid sample is accepted; rst (sync, active-high) wins over in_valid.
// Ports: clk, rst, chk (gray_checker_if.slave: in_valid, gray_in -> out_valid, bin_out,
//        locked, step_err, wrap, err_count).
// Build option: GRAY_CHECKER_STRICT_EN makes a held (repeated) count a step error.
module gray_checker #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    gray_checker_if.slave   chk
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    // bin_q doubles as the "previous sample" reference: both are the decode
    // of the last valid sample and both reset to zero.
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 out_valid_q, out_valid_d;
    logic                 step_err_q, step_err_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]     cur_bin;
    logic [WIDTH-1:0]     succ_bin;
    logic                 bad_step;

    // b[i] is the XOR of all Gray bits at or above i.
    always_comb begin
        cur_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cur_bin[i] = ^(chk.gray_in >> i);
        end
    end

    assign succ_bin = bin_q + WIDTH'(1);

    always_comb begin
        bad_step = 1'b0;
        if (cur_bin == succ_bin) begin
            bad_step = 1'b0;
        end else if (cur_bin == bin_q) begin
`ifdef GRAY_CHECKER_STRICT_EN
            bad_step = 1'b1;
`else
            bad_step = 1'b0;
`endif
        end else begin
            bad_step = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        out_valid_d = 1'b0;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (chk.in_valid) begin
            out_valid_d = 1'b1;
            bin_d       = cur_bin;
            case (state_q)
                UNLOCKED: begin
                    // First sample only establishes the reference.
                    state_d = LOCKED;
                end
                LOCKED: begin
                    if (bad_step) begin
                        step_err_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end else if (cur_bin == succ_bin) begin
                        wrap_d = &bin_q;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign chk.out_valid = out_valid_q;
    assign chk.bin_out   = bin_q;
    assign chk.locked    = (state_q == LOCKED);
    assign chk.step_err  = step_err_q;
    assign chk.wrap      = wrap_q;
    assign chk.err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_checker.sv
module tb_gray_checker;

    logic clk;
    logic rst;

    gray_checker_if #(.WIDTH(3), .ERR_CNT_W(8)) if8 ();
    gray_checker_if #(.WIDTH(3), .ERR_CNT_W(2)) if2 ();

    gray_checker #(.WIDTH(3), .ERR_CNT_W(8)) dut8 (.clk(clk), .rst(rst), .chk(if8.slave));
    gray_checker #(.WIDTH(3), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .chk(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] g;
        logic       e_vld;
        logic [2:0] e_bin;
        logic       e_lock;
        logic       e_err;    // default build
        logic       e_err_s;  // strict build
        logic       e_wrap;
    } vec_t;

    typedef struct {
        string      name;
        logic       e_vld;
        logic [2:0] e_bin;
        logic       e_lock;
        logic       e_err;
        logic       e_wrap;
        int         c8;
        int         c2;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cnt8  = 0;
    int cnt2  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [2:0] g,
                       input logic ev, input logic [2:0] eb, input logic el,
                       input logic ee, input logic es, input logic ew);
        vec_t t;
        t.rst = r; t.vld = v; t.g = g;
        t.e_vld = ev; t.e_bin = eb; t.e_lock = el;
        t.e_err = ee; t.e_err_s = es; t.e_wrap = ew;
        vecs.push_back(t);
    endtask

    // Drive one cycle, push the expectation, then compare after the edge.
    task automatic apply(input string nm, input vec_t t);
        exp_t e;
        logic err;
`ifdef GRAY_CHECKER_STRICT_EN
        err = t.e_err_s;
`else
        err = t.e_err;
`endif
        rst          = t.rst;
        if8.in_valid = t.vld;
        if8.gray_in  = t.g;
        if2.in_valid = t.vld;
        if2.gray_in  = t.g;
        if (t.rst) begin
            cnt8 = 0;
            cnt2 = 0;
        end else if (err) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3)   cnt2++;
        end
        e.name = nm; e.e_vld = t.e_vld; e.e_bin = t.e_bin; e.e_lock = t.e_lock;
        e.e_err = err; e.e_wrap = t.e_wrap; e.c8 = cnt8; e.c2 = cnt2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.name, " out_valid"}, 32'(if8.out_valid), 32'(e.e_vld));
        check({e.name, " bin_out"},   32'(if8.bin_out),   32'(e.e_bin));
        check({e.name, " locked"},    32'(if8.locked),    32'(e.e_lock));
        check({e.name, " step_err"},  32'(if8.step_err),  32'(e.e_err));
        check({e.name, " wrap"},      32'(if8.wrap),      32'(e.e_wrap));
        check({e.name, " err_count"}, 32'(if8.err_count), 32'(e.c8));
        check({e.name, " err_count_w2"}, 32'(if2.err_count), 32'(e.c2));
        check({e.name, " step_err_w2"},  32'(if2.step_err),  32'(e.e_err));
    endtask

    initial begin
        vec_t h;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.gray_in = '0;
        if2.in_valid = 1'b0; if2.gray_in = '0;

        //  rst vld g       vld bin   lock err errS wrap
        add(1, 0, 3'b000,  0, 3'd0, 0, 0, 0, 0);  // reset state
        add(0, 0, 3'b000,  0, 3'd0, 0, 0, 0, 0);  // idle, stays unlocked
        add(1, 1, 3'b101,  0, 3'd0, 0, 0, 0, 0);  // rst beats in_valid
        add(0, 0, 3'b000,  0, 3'd0, 0, 0, 0, 0);
        // full Gray cycle
        add(0, 1, 3'b000,  1, 3'd0, 1, 0, 0, 0);
        add(0, 1, 3'b001,  1, 3'd1, 1, 0, 0, 0);
        add(0, 1, 3'b011,  1, 3'd2, 1, 0, 0, 0);
        add(0, 1, 3'b010,  1, 3'd3, 1, 0, 0, 0);
        add(0, 1, 3'b110,  1, 3'd4, 1, 0, 0, 0);
        add(0, 1, 3'b111,  1, 3'd5, 1, 0, 0, 0);
        add(0, 1, 3'b101,  1, 3'd6, 1, 0, 0, 0);
        add(0, 1, 3'b100,  1, 3'd7, 1, 0, 0, 0);
        add(0, 1, 3'b000,  1, 3'd0, 1, 0, 0, 1);  // 7 -> 0 wraps
        // gaps, holds, illegal steps
        add(0, 0, 3'b111,  0, 3'd0, 1, 0, 0, 0);
        add(0, 1, 3'b001,  1, 3'd1, 1, 0, 0, 0);
        add(0, 0, 3'b110,  0, 3'd1, 1, 0, 0, 0);
        add(0, 1, 3'b011,  1, 3'd2, 1, 0, 0, 0);
        add(0, 1, 3'b011,  1, 3'd2, 1, 0, 1, 0);  // hold
        add(0, 1, 3'b010,  1, 3'd3, 1, 0, 0, 0);
        add(0, 1, 3'b000,  1, 3'd0, 1, 1, 1, 0);  // 3 -> 0 illegal, no wrap
        add(0, 1, 3'b001,  1, 3'd1, 1, 0, 0, 0);
        add(0, 1, 3'b010,  1, 3'd3, 1, 1, 1, 0);  // 1 -> 3 illegal
        add(0, 1, 3'b110,  1, 3'd4, 1, 0, 0, 0);  // 3 -> 4 legal again
        // mid-stream reset with a valid sample, then re-lock without check
        add(1, 1, 3'b010,  0, 3'd0, 0, 0, 0, 0);
        add(0, 1, 3'b101,  1, 3'd6, 1, 0, 0, 0);
        // five illegal steps: narrow counter saturates at 3
        add(0, 1, 3'b010,  1, 3'd3, 1, 1, 1, 0);
        add(0, 1, 3'b101,  1, 3'd6, 1, 1, 1, 0);
        add(0, 1, 3'b010,  1, 3'd3, 1, 1, 1, 0);
        add(0, 1, 3'b101,  1, 3'd6, 1, 1, 1, 0);
        add(0, 1, 3'b010,  1, 3'd3, 1, 1, 1, 0);
        add(0, 1, 3'b110,  1, 3'd4, 1, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("row%0d", i), vecs[i]);
        end

        // Long idle stretch: everything holds, then the next legal step is accepted.
        for (int k = 0; k < 3; k++) begin
            h.rst = 0; h.vld = 0; h.g = 3'($urandom_range(0, 7));
            h.e_vld = 0; h.e_bin = 3'd4; h.e_lock = 1;
            h.e_err = 0; h.e_err_s = 0; h.e_wrap = 0;
            apply($sformatf("idle%0d", k), h);
        end
        h.rst = 0; h.vld = 1; h.g = 3'b111;
        h.e_vld = 1; h.e_bin = 3'd5; h.e_lock = 1;
        h.e_err = 0; h.e_err_s = 0; h.e_wrap = 0;
        apply("after_idle", h);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_checker.md
# gray_checker

Receive-side companion to `gray_counter`. The block samples a Gray-coded count bus each clock it is marked valid, decodes it to binary, and checks that successive samples advance by exactly one step modulo 2^WIDTH. It reports step errors, wrap events and a saturating error count. It sits downstream of any Gray-coded counter (e.g. a CDC pointer or the 3-bit `gray` output) and serves as both a functional decoder and an in-system protocol monitor.

## Interface
- `WIDTH`, 3: width of the Gray input and binary output, ≥2.
- `ERR_CNT_W`, 8: width of the error counter, ≥1.

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `gray_in` is a sample this cycle.
- `gray_in`  in  WIDTH: Gray-coded count.
- `out_valid`  out  1: `bin_out` and the status pulses are valid this cycle.
- `bin_out`  out  WIDTH: registered binary decode of the last valid sample.
- `locked`  out  1: at least one sample has been taken since reset.
- `step_err`  out  1: 1-cycle pulse, qualified by `out_valid`; the sample was not a legal successor.
- `wrap`  out  1: 1-cycle pulse, qualified by `out_valid`; a legal step from all-ones to zero.
- `err_count`  out  ERR_CNT_W: saturating count of `step_err` pulses.

## Operation
- Decode: `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = b[i+1] ^ g[i]`.
- The decode is purely combinational into the output register.
- State machine, 2 states:
  - UNLOCKED (reset state): the first valid sample is decoded and stored as `prev`. `out_valid`=1, no check, `step_err`=0, `wrap`=0. The next state is LOCKED.
  - LOCKED: on each valid sample, decode to `cur` and compare it with `prev`:
    - `cur == prev+1 (mod 2^WIDTH)`: legal, `step_err`=0. `wrap`=1 if `prev` is all-ones.
    - `cur == prev` (hold): legal unless the strict build is enabled (see Configuration).
    - Any other value: `step_err`=1 and `err_count` increments.
    - After every valid sample, `prev <= cur`. This resynchronizes the checker, so one bad sample yields at most 2 errors: entering and leaving it.
  - LOCKED exits only on `rst`.
- `err_count` saturates at 2^ERR_CNT_W−1 and never wraps.
- With `in_valid`=0: no state change. `out_valid`, `step_err` and `wrap` are 0. `bin_out` and `err_count` hold.

## Timing
- Latency 1: a sample with `in_valid`=1 at edge k produces `out_valid`, `bin_out`, `step_err`, `wrap` and `locked` after edge k.
- `err_count` updates at the same edge as its `step_err` pulse.
- Accepts one sample per cycle with no stall and no back-pressure.
- Reset values (after any edge with `rst`=1): `out_valid`=0, `bin_out`=0, `locked`=0, `step_err`=0, `wrap`=0, `err_count`=0, `prev`=0, state UNLOCKED.
- `rst` has priority over `in_valid` in the same cycle; that sample is discarded.
- Reset mid-stream: the first valid sample after reset re-locks with no check, so no spurious error.

## Configuration
- `GRAY_CHECKER_STRICT_EN`:
  - Defined: a hold (`cur == prev`) in LOCKED is an error. It pulses `step_err` and increments `err_count`. Use this when the source must advance every valid cycle.
  - Undefined (default): a hold is legal and silent.

## Test plan
- Gray sequence 000,001,011,010,110,111,101,100,000, one per cycle with `in_valid`=1 → `bin_out` = 0,1,2,…,7,0 with 1-cycle latency. `locked`=1 after the first sample. `wrap`=1 only on the final sample. `err_count`=0.
- Samples 000,001,010 (binary 0,1,3) → `step_err` pulses on the third sample only; `err_count`=1; the next sample 110 (4) is legal.
- Samples 011,011 in the default build → no error. With `GRAY_CHECKER_STRICT_EN` defined → `step_err`=1, `err_count`=1.
- `ERR_CNT_W`=2 with 5 illegal steps → `err_count` reads 1,2,3,3,3.
- Gaps of `in_valid`=0 between legal samples → no pulses, outputs hold. `rst` asserted mid-stream, then first sample 101 → all outputs 0 for the reset cycle, then `bin_out`=6, `step_err`=0, `locked`=1.
- `rst`=1 and `in_valid`=1 in the same cycle → sample ignored, `locked` stays 0.
